// File: rtl/t03_pc_branch.sv
// Program counter and branch resolution stage for the team-03 core.
// Resolves conditional branches from ALU flags, computes JAL/JALR targets,
// holds the architectural PC and sequences instruction fetch with a
// request/acknowledge handshake.
// Build option: define T03_MISALIGN_TRAP_EN to trap on a misaligned next PC.
// The trap sets a sticky err and parks the stage in HALT until reset.
// Without the macro the low two bits of the next PC are forced to zero.
module t03_pc_branch #(
  parameter logic [31:0] RESET_PC = 32'h3300_0000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [31:0] result,
  input  logic        Z,
  input  logic        N,
  input  logic        V,
  input  logic [31:0] rs1_u,
  input  logic [31:0] rs2_u,
  input  logic [31:0] imm_gen,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic [2:0]  bop,
  input  logic        instr_ack,
  input  logic        hold,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_req,
  output logic        instr_valid,
  output logic        taken,
  output logic [31:0] instret,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StStall
`ifdef T03_MISALIGN_TRAP_EN
    , StHalt
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instret_q;
  logic        cond;
  logic        redirect;
  logic [31:0] target_add;
  logic [31:0] next_pc_raw;
  logic [31:0] next_pc;
  logic        update;

  // JALR always clears bit 0, so that bit of the ALU result is never used.
  logic unused_result0;
  assign unused_result0 = result[0];

  assign pc_plus4   = pc_q + 32'd4;
  assign target_add = pc_q + imm_gen;
  assign pc         = pc_q;
  assign instret    = instret_q;

  // Branch condition decoded from funct3 and the rs1-rs2 flags.
  always_comb begin
    cond = 1'b0;
    case (bop)
      3'b000:  cond = Z;
      3'b001:  cond = ~Z;
      3'b100:  cond = N ^ V;
      3'b101:  cond = ~(N ^ V);
      3'b110:  cond = rs1_u < rs2_u;
      3'b111:  cond = ~(rs1_u < rs2_u);
      default: cond = 1'b0;
    endcase
  end

  // Next-PC selection: jalr beats jump, and either jump masks a branch.
  always_comb begin
    redirect    = 1'b1;
    next_pc_raw = pc_plus4;
    if (jalr) begin
      next_pc_raw = {result[31:1], 1'b0};
    end else if (jump) begin
      next_pc_raw = target_add;
    end else if (branch && cond) begin
      next_pc_raw = target_add;
    end else begin
      redirect = 1'b0;
    end
  end

`ifdef T03_MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;
  assign next_pc  = next_pc_raw;
  assign misalign = next_pc_raw[1:0] != 2'b00;
  assign err      = err_q;
`else
  logic [1:0] unused_low_bits;
  assign unused_low_bits = next_pc_raw[1:0];
  assign next_pc         = {next_pc_raw[31:2], 2'b00};
  assign err             = 1'b0;
`endif

  // Next-state and handshake outputs; update marks an instruction retiring.
  always_comb begin
    state_d     = state_q;
    fetch_req   = 1'b0;
    instr_valid = 1'b0;
    taken       = 1'b0;
    update      = 1'b0;
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        fetch_req = 1'b1;
        if (instr_ack) state_d = StExec;
      end
      StExec, StStall: begin
        instr_valid = 1'b1;
        taken       = redirect;
        if (hold) begin
          state_d = StStall;
`ifdef T03_MISALIGN_TRAP_EN
        end else if (misalign) begin
          state_d = StHalt;
`endif
        end else begin
          update  = 1'b1;
          state_d = StFetch;
        end
      end
`ifdef T03_MISALIGN_TRAP_EN
      StHalt:  state_d = StHalt;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Architectural state: FSM, PC and retired-instruction counter.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (update) begin
        pc_q      <= next_pc;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

`ifdef T03_MISALIGN_TRAP_EN
  // Sticky error, set on the cycle that enters HALT.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      err_q <= 1'b0;
    end else if ((state_q == StExec || state_q == StStall) && !hold && misalign) begin
      err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_t03_pc_branch.sv
// Testbench for t03_pc_branch: scoreboard of expected PC/instret/taken per
// instruction, plus a second instance reset near the top of the address space.
module tb_t03_pc_branch;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic [31:0] result = '0, rs1_u = '0, rs2_u = '0, imm_gen = '0;
  logic        Z = 1'b0, N = 1'b0, V = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, jalr = 1'b0;
  logic [2:0]  bop = '0;
  logic        instr_ack = 1'b0, hold = 1'b0;

  logic [31:0] pc, pc_plus4, instret;
  logic        fetch_req, instr_valid, taken, err;
  logic [31:0] w_pc, w_pc_plus4, w_instret;
  logic        w_fetch_req, w_instr_valid, w_taken, w_err;

  t03_pc_branch u_dut (
    .clk(clk), .nRst(nRst), .result(result), .Z(Z), .N(N), .V(V),
    .rs1_u(rs1_u), .rs2_u(rs2_u), .imm_gen(imm_gen), .branch(branch), .jump(jump),
    .jalr(jalr), .bop(bop), .instr_ack(instr_ack), .hold(hold), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_req(fetch_req), .instr_valid(instr_valid),
    .taken(taken), .instret(instret), .err(err)
  );

  t03_pc_branch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .nRst(nRst), .result(result), .Z(Z), .N(N), .V(V),
    .rs1_u(rs1_u), .rs2_u(rs2_u), .imm_gen(imm_gen), .branch(branch), .jump(jump),
    .jalr(jalr), .bop(bop), .instr_ack(instr_ack), .hold(hold), .pc(w_pc),
    .pc_plus4(w_pc_plus4), .fetch_req(w_fetch_req), .instr_valid(w_instr_valid),
    .taken(w_taken), .instret(w_instret), .err(w_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        tk;
  } exp_t;

  typedef struct packed {
    logic        jr, j, b;
    logic [2:0]  op;
    logic        z, n, v;
    logic [31:0] res, imm, a, bb;
    logic        tk;
    logic [31:0] pc;
  } step_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_ir = '0;

  task automatic set_ctrl(input logic jr, j, b, input logic [2:0] op, input logic z, n, v,
                          input logic [31:0] res, imm, a, bb);
    jalr = jr; jump = j; branch = b; bop = op; Z = z; N = n; V = v;
    result = res; imm_gen = imm; rs1_u = a; rs2_u = bb;
  endtask

  // Waits (bounded) for a fetch request, acknowledges it, ends in EXEC.
  task automatic fetch_to_exec();
    int n = 0;
    while (fetch_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (fetch_req !== 1'b1) begin
      fails++;
      $display("FAIL fetch_timeout: fetch_req=%b after %0d cycles, required 1", fetch_req, n);
    end
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
    tests++;
    if (instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL exec_entry: instr_valid=%b required 1", instr_valid);
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (pc !== 32'h3300_0000 || instret !== 0 || fetch_req !== 0 || instr_valid !== 0 ||
        taken !== 0 || err !== 0) begin
      fails++;
      $display("FAIL reset_values: pc=%h instret=%h fr=%b iv=%b tk=%b err=%b required 3300_0000/0/0/0/0/0",
               pc, instret, fetch_req, instr_valid, taken, err);
    end
    tests++;
    if (w_pc !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL reset_pc_param: pc=%h required ffff_fffc", w_pc);
    end
    nRst = 1'b1;
    #1;
    tests++;
    if (fetch_req !== 1'b0) begin
      fails++;
      $display("FAIL idle_cycle: fetch_req=%b required 0", fetch_req);
    end
    @(negedge clk);
    tests++;
    if (fetch_req !== 1'b1) begin
      fails++;
      $display("FAIL first_fetch: fetch_req=%b required 1", fetch_req);
    end
    @(negedge clk);
    tests++;
    if (fetch_req !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL fetch_wait: fr=%b iv=%b required 1/0", fetch_req, instr_valid);
    end
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
    tests++;
    if (instr_valid !== 1'b1 || pc !== 32'h3300_0000) begin
      fails++;
      $display("FAIL exec_after_ack: iv=%b pc=%h required 1/3300_0000", instr_valid, pc);
    end
  endtask

  // Continues from EXEC left by test_reset.
  task automatic test_seq_wrap();
    exp_t e;
    set_ctrl(0, 0, 0, 3'b000, 0, 0, 0, '0, '0, '0, '0);
    model_ir++;
    sb_q.push_back('{pc: 32'h3300_0004, ir: model_ir, tk: 1'b0});
    tests++;
    if (taken !== sb_q[0].tk) begin
      fails++;
      $display("FAIL seq_taken: taken=%b required %b", taken, sb_q[0].tk);
    end
    @(negedge clk);
    e = sb_q.pop_front();
    tests++;
    if (pc !== e.pc || instret !== e.ir || pc_plus4 !== e.pc + 32'd4) begin
      fails++;
      $display("FAIL seq_pc: pc=%h instret=%h pc_plus4=%h required %h/%h/%h",
               pc, instret, pc_plus4, e.pc, e.ir, e.pc + 32'd4);
    end
    tests++;
    if (w_pc !== 32'h0 || w_instret !== 32'd1 || w_pc_plus4 !== 32'd4) begin
      fails++;
      $display("FAIL pc_wrap: pc=%h instret=%h pc_plus4=%h required 0/1/4",
               w_pc, w_instret, w_pc_plus4);
    end
  endtask

  task automatic test_jalr_priority();
    exp_t e;
    set_ctrl(1, 1, 1, 3'b000, 1, 0, 0, 32'h3300_0101, 32'h40, '0, '0);
    model_ir++;
    sb_q.push_back('{pc: 32'h3300_0100, ir: model_ir, tk: 1'b1});
    fetch_to_exec();
    tests++;
    if (taken !== sb_q[0].tk) begin
      fails++;
      $display("FAIL jalr_taken: taken=%b required %b", taken, sb_q[0].tk);
    end
    @(negedge clk);
    e = sb_q.pop_front();
    tests++;
    if (pc !== e.pc || instret !== e.ir) begin
      fails++;
      $display("FAIL jalr_pc: pc=%h instret=%h required %h/%h", pc, instret, e.pc, e.ir);
    end
  endtask

  task automatic test_branches();
    step_t tbl[12];
    exp_t  e;
    tbl[0]  = '{jr:1, j:0, b:0, op:3'b000, z:0, n:0, v:0, res:32'h3300_0010, imm:0,
                a:0, bb:0, tk:1, pc:32'h3300_0010};
    tbl[1]  = '{jr:0, j:0, b:1, op:3'b100, z:0, n:1, v:0, res:0, imm:32'hFFFF_FFF8,
                a:0, bb:0, tk:1, pc:32'h3300_0008};
    tbl[2]  = tbl[0];
    tbl[3]  = '{jr:0, j:0, b:1, op:3'b100, z:0, n:1, v:1, res:0, imm:32'hFFFF_FFF8,
                a:0, bb:0, tk:0, pc:32'h3300_0014};
    tbl[4]  = '{jr:0, j:0, b:1, op:3'b111, z:0, n:0, v:0, res:0, imm:32'h20,
                a:32'hFFFF_FFFF, bb:1, tk:1, pc:32'h3300_0034};
    tbl[5]  = '{jr:0, j:0, b:1, op:3'b110, z:0, n:0, v:0, res:0, imm:32'h20,
                a:32'hFFFF_FFFF, bb:1, tk:0, pc:32'h3300_0038};
    tbl[6]  = '{jr:0, j:0, b:1, op:3'b000, z:1, n:0, v:0, res:0, imm:32'h10,
                a:0, bb:0, tk:1, pc:32'h3300_0048};
    tbl[7]  = '{jr:0, j:0, b:1, op:3'b001, z:1, n:0, v:0, res:0, imm:32'h10,
                a:0, bb:0, tk:0, pc:32'h3300_004C};
    tbl[8]  = '{jr:0, j:0, b:1, op:3'b010, z:1, n:0, v:0, res:0, imm:32'h10,
                a:0, bb:0, tk:0, pc:32'h3300_0050};
    tbl[9]  = '{jr:0, j:1, b:1, op:3'b001, z:1, n:0, v:0, res:0, imm:32'h40,
                a:0, bb:0, tk:1, pc:32'h3300_0090};
    tbl[10] = '{jr:0, j:0, b:1, op:3'b101, z:0, n:1, v:1, res:0, imm:32'h10,
                a:0, bb:0, tk:1, pc:32'h3300_00A0};
    tbl[11] = '{jr:0, j:0, b:0, op:3'b000, z:1, n:0, v:0, res:0, imm:32'h100,
                a:0, bb:0, tk:0, pc:32'h3300_00A4};
    for (int i = 0; i < 12; i++) begin
      set_ctrl(tbl[i].jr, tbl[i].j, tbl[i].b, tbl[i].op, tbl[i].z, tbl[i].n, tbl[i].v,
               tbl[i].res, tbl[i].imm, tbl[i].a, tbl[i].bb);
      model_ir++;
      sb_q.push_back('{pc: tbl[i].pc, ir: model_ir, tk: tbl[i].tk});
      fetch_to_exec();
      tests++;
      if (taken !== sb_q[0].tk) begin
        fails++;
        $display("FAIL branch_taken[%0d]: taken=%b required %b", i, taken, sb_q[0].tk);
      end
      @(negedge clk);
      e = sb_q.pop_front();
      tests++;
      if (pc !== e.pc || instret !== e.ir) begin
        fails++;
        $display("FAIL branch_pc[%0d]: pc=%h instret=%h required %h/%h",
                 i, pc, instret, e.pc, e.ir);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    set_ctrl(0, 0, 0, 3'b000, 0, 0, 0, '0, '0, '0, '0);
    model_ir++;
    sb_q.push_back('{pc: 32'h3300_00A8, ir: model_ir, tk: 1'b0});
    fetch_to_exec();
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (pc !== 32'h3300_00A4 || instret !== model_ir - 32'd1 || instr_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold[%0d]: pc=%h instret=%h iv=%b required 3300_00a4/%h/1",
                 c, pc, instret, instr_valid, model_ir - 32'd1);
      end
    end
    hold = 1'b0;
    @(negedge clk);
    e = sb_q.pop_front();
    tests++;
    if (pc !== e.pc || instret !== e.ir || fetch_req !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: pc=%h instret=%h fr=%b required %h/%h/1",
               pc, instret, fetch_req, e.pc, e.ir);
    end
  endtask

  task automatic test_misalign();
    exp_t e;
    set_ctrl(0, 1, 0, 3'b000, 0, 0, 0, '0, 32'd6, '0, '0);
`ifdef T03_MISALIGN_TRAP_EN
    sb_q.push_back('{pc: 32'h3300_00A8, ir: model_ir, tk: 1'b1});
`else
    model_ir++;
    sb_q.push_back('{pc: 32'h3300_00AC, ir: model_ir, tk: 1'b1});
`endif
    fetch_to_exec();
    tests++;
    if (taken !== sb_q[0].tk) begin
      fails++;
      $display("FAIL misalign_taken: taken=%b required %b", taken, sb_q[0].tk);
    end
    @(negedge clk);
    e = sb_q.pop_front();
    tests++;
    if (pc !== e.pc || instret !== e.ir) begin
      fails++;
      $display("FAIL misalign_pc: pc=%h instret=%h required %h/%h", pc, instret, e.pc, e.ir);
    end
`ifdef T03_MISALIGN_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (err !== 1'b1 || fetch_req !== 1'b0 || instr_valid !== 1'b0 || pc !== e.pc) begin
        fails++;
        $display("FAIL misalign_halt[%0d]: err=%b fr=%b iv=%b pc=%h required 1/0/0/%h",
                 c, err, fetch_req, instr_valid, pc, e.pc);
      end
      @(negedge clk);
    end
`else
    tests++;
    if (err !== 1'b0 || fetch_req !== 1'b1) begin
      fails++;
      $display("FAIL misalign_noerr: err=%b fr=%b required 0/1", err, fetch_req);
    end
`endif
  endtask

  task automatic test_async_reset();
    exp_t e;
    set_ctrl(0, 0, 0, 3'b000, 0, 0, 0, '0, '0, '0, '0);
    #2;
    nRst = 1'b0;
    #1;
    tests++;
    if (pc !== 32'h3300_0000 || instret !== 0 || err !== 0 || fetch_req !== 0 ||
        instr_valid !== 0 || w_pc !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL async_reset: pc=%h instret=%h err=%b fr=%b iv=%b wpc=%h required 3300_0000/0/0/0/0/ffff_fffc",
               pc, instret, err, fetch_req, instr_valid, w_pc);
    end
    @(negedge clk);
    nRst = 1'b1;
    model_ir = 32'd1;
    sb_q.push_back('{pc: 32'h3300_0004, ir: model_ir, tk: 1'b0});
    fetch_to_exec();
    @(negedge clk);
    e = sb_q.pop_front();
    tests++;
    if (pc !== e.pc || instret !== e.ir) begin
      fails++;
      $display("FAIL post_reset_seq: pc=%h instret=%h required %h/%h", pc, instret, e.pc, e.ir);
    end
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_jalr_priority();
    test_branches();
    test_stall();
    test_misalign();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/t03_pc_branch.md
# t03_pc_branch

Program-counter and branch-resolution stage that sits directly downstream of the team-03 ALU. It consumes the ALU `result` and Z/N/V flags to resolve conditional branches and JAL/JALR targets, holds the architectural PC, and sequences instruction fetch with a request/acknowledge handshake. Its `pc` output feeds the instruction-memory interface. Its `pc_plus4` output feeds the register-file write mux as the link value.

## Interface
- `RESET_PC`, default 32'h3300_0000: PC value loaded on reset.
- `clk`  in  1: system clock, rising edge.
- `nRst`  in  1: asynchronous, active-low reset.
- `result`  in  32: ALU result; used as the JALR target.
- `Z`, `N`, `V`  in  1 each: ALU flags from rs1−rs2 (FOP_SUB).
- `rs1_u`, `rs2_u`  in  32: unsigned operands, used only for BLTU/BGEU.
- `imm_gen`  in  32: signed branch/JAL offset.
- `branch`, `jump`, `jalr`  in  1 each: instruction class from the decoder.
- `bop`  in  3: funct3 branch condition.
- `instr_ack`  in  1: instruction memory has returned the word for `pc`.
- `hold`  in  1: data-memory stall request.
- `pc`  out  32: current PC. Reset value is `RESET_PC`.
- `pc_plus4`  out  32: `pc`+4, modulo 2^32.
- `fetch_req`  out  1: fetch request. Reset value 0.
- `instr_valid`  out  1: fetched instruction is in execute. Reset value 0.
- `taken`  out  1: redirect is taken this instruction. Reset value 0.
- `instret`  out  32: count of retired instructions. Reset value 0.
- `err`  out  1: sticky misalignment error. Reset value 0. Driven only when the trap build is enabled.

## Operation
- **States:** IDLE, FETCH, EXEC, STALL, plus HALT when the trap build is enabled. Reset state is IDLE.
- **IDLE:** `fetch_req`=0. Moves to FETCH unconditionally on the next cycle.
- **FETCH:** `fetch_req`=1. Stays in FETCH until `instr_ack`=1, then moves to EXEC.
- **EXEC:** `instr_valid`=1.
  - If `hold`=1, move to STALL; the PC is not updated.
  - Otherwise `pc`<=next_pc, `instret`<=`instret`+1, and move to FETCH.
- **STALL:** `instr_valid`=1. Stays while `hold`=1. When `hold` falls, perform the same update as EXEC and move to FETCH.
  - Upstream keeps flags, operands and controls stable throughout STALL.
- **Branch condition, combinational:**
  - BEQ 000: Z.
  - BNE 001: !Z.
  - BLT 100: N^V.
  - BGE 101: !(N^V).
  - BLTU 110: `rs1_u`<`rs2_u`.
  - BGEU 111: !(`rs1_u`<`rs2_u`).
  - Other `bop` codes: not taken.
- **next_pc priority:**
  1. `jalr`: {`result`[31:1],1'b0}.
  2. `jump`: `pc`+`imm_gen`.
  3. `branch` with condition true: `pc`+`imm_gen`.
  4. Otherwise `pc`+4.
- **`taken`:** 1 in EXEC/STALL when case 1, 2 or 3 applies; 0 in all other states.
- **Arithmetic:** all adds are 32-bit and wrap modulo 2^32. PC 32'hFFFF_FFFC with no redirect goes to 32'h0000_0000. `instret` wraps from 32'hFFFF_FFFF to 0.
- **Conflicts:** if `jalr` and `jump` are both set, `jalr` wins. A `branch` set alongside either jump is ignored.

## Timing
- `pc`, state and `instret` are registered. `fetch_req`, `instr_valid`, `taken` and `pc_plus4` are decoded combinationally from registered state and inputs.
- Minimum of 2 cycles per instruction: FETCH with ack in the same cycle, then EXEC.
- The new `pc` is visible on the edge that leaves EXEC/STALL. `fetch_req` rises in that same cycle.
- `instr_ack` is ignored outside FETCH.
- `hold` is ignored outside EXEC/STALL.
- Reset assertion in any state asynchronously forces all outputs to their reset values and the state to IDLE. The first `fetch_req` appears 1 cycle after `nRst` deasserts.

## Configuration
- **`T03_MISALIGN_TRAP_EN` defined:**
  - In EXEC or STALL with `hold`=0, if next_pc[1:0]!=0: `pc` is not updated, `instret` is not incremented, `err`<=1, and the state goes to HALT.
  - HALT drives `fetch_req`=0 and `instr_valid`=0, and is left only by reset.
- **Macro undefined:** next_pc[1:0] is forced to 2'b00, there is no HALT state, and `err` is tied to 0.

## Test plan
- **Reset/fetch:** release `nRst`, ack on the 2nd FETCH cycle → `fetch_req`=0 for 1 cycle, then 1. `pc`=32'h3300_0000. `instr_valid` is high 1 cycle later.
- **Sequential with wrap:** force `pc`=32'hFFFF_FFFC via RESET_PC, no redirect → next `pc`=0, `instret`=1.
- **Branches:**
  - BLT with N=1, V=0, `imm_gen`=−8 at `pc`=32'h3300_0010 → `taken`=1, `pc`=32'h3300_0008.
  - Same case with V=1 → `pc`=32'h3300_0014.
  - BGEU with `rs1_u`=32'hFFFF_FFFF, `rs2_u`=1 → taken.
- **JALR priority:** `jalr`=`jump`=1, `result`=32'h3300_0101 → `pc`=32'h3300_0100.
- **Stall:** `hold` high for 3 cycles in EXEC → `pc` is unchanged for 3 cycles, `instret` increments once, after `hold` falls.
- **Misalignment:** JAL with `imm_gen`=6.
  - With `T03_MISALIGN_TRAP_EN`: `err`=1, `pc` holds, `fetch_req` stays 0.
  - Without the macro: `pc`=`pc`+4.
